// File: rtl/system_fifo_pkg.sv
// Shared types and defaults for the per-step PV result FIFO sequencer.
package system_fifo_pkg;

    localparam int unsigned N_PV_DEF   = 16;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } seq_state_e;

    // Bits needed to count 0..n inclusive
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_w(N_PV_DEF);

endpackage

// File: rtl/valid_delay_line.sv
// RD_LAT-stage valid shift register that lines out_valid up with FIFO read data.
module valid_delay_line
    import system_fifo_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_valid,
    output logic o_valid,
    output logic o_empty_c
);

    // Every stage except the output one
    localparam logic [RD_LAT-1:0] UP_MASK = RD_LAT'((32'd1 << (RD_LAT - 1)) - 32'd1);

    logic [RD_LAT-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else if (i_clr) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | RD_LAT'(i_valid);
        end
    end

    assign o_valid = r_pipe[RD_LAT-1];
    // High when nothing is in flight beyond the word now presented on o_valid
    assign o_empty_c = ~i_valid & ~|(r_pipe & UP_MASK);

endmodule

// File: rtl/system_fifo_sequencer.sv
// Per-step write/drain sequencer for the PV result FIFO with counted handshakes
// and sticky protocol error reporting.
module system_fifo_sequencer
    import system_fifo_pkg::*;
#(
    parameter int unsigned N_PV   = N_PV_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF,
    parameter int unsigned CNT_W  = cnt_w(N_PV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rst_user,
    input  logic i_step_start,
    input  logic i_src_valid,
    input  logic i_fifo_full,
    input  logic i_fifo_empty,
    output logic o_wr_en,
    output logic o_rd_en,
    output logic o_out_valid,
    output logic o_busy,
    output logic o_step_done,
    output logic o_err_ovf,
    output logic o_err_unf,
    output logic o_err_overrun
);

    // A step can never move more words than the FIFO holds
    localparam int unsigned N_EFF = (N_PV > DEPTH) ? DEPTH : N_PV;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_EFF);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_EFF - 1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_busy;
    logic             r_step_done;
    logic             r_err_ovf;
    logic             r_err_unf;
    logic             r_err_overrun;
    logic             w_wr;
    logic             w_rd;
    logic             w_clr_cnt;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_set_ovr;
    logic             w_dl_empty;

    always_comb begin
        w_next    = r_state;
        w_wr      = 1'b0;
        w_rd      = 1'b0;
        w_clr_cnt = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        w_set_ovr = i_step_start & (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (i_step_start) begin
                    w_next    = ST_FILL;
                    w_clr_cnt = 1'b1;
                end
            end
            ST_FILL: begin
                w_wr      = i_src_valid & ~i_fifo_full;
                w_set_ovf = i_src_valid & i_fifo_full;
                if (w_wr && (r_wr_cnt == LAST)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_rd      = (r_rd_cnt < N_CNT) & ~i_fifo_empty;
                w_set_unf = (r_rd_cnt < N_CNT) & i_fifo_empty;
                if (w_rd && (r_rd_cnt == LAST)) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_dl_empty) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (i_rst_user) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != ST_IDLE);
            r_step_done <= (w_next == ST_DONE);
        end
    end

    // Word counters saturate at the step size
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (i_rst_user || w_clr_cnt) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr && (r_wr_cnt != N_CNT)) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_rd && (r_rd_cnt != N_CNT)) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf     <= 1'b0;
            r_err_unf     <= 1'b0;
            r_err_overrun <= 1'b0;
        end else if (i_rst_user) begin
            r_err_ovf     <= 1'b0;
            r_err_unf     <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_ovf     <= r_err_ovf | w_set_ovf;
            r_err_unf     <= r_err_unf | w_set_unf;
            r_err_overrun <= r_err_overrun | w_set_ovr;
        end
    end

    valid_delay_line #(
        .RD_LAT (RD_LAT)
    ) u_valid_dl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (i_rst_user),
        .i_valid   (w_rd),
        .o_valid   (o_out_valid),
        .o_empty_c (w_dl_empty)
    );

    assign o_wr_en       = w_wr;
    assign o_rd_en       = w_rd;
    assign o_busy        = r_busy;
    assign o_step_done   = r_step_done;
    assign o_err_ovf     = r_err_ovf;
    assign o_err_unf     = r_err_unf;
    assign o_err_overrun = r_err_overrun;

endmodule

// File: doc/system_fifo_sequencer.md
# system_fifo_sequencer

Per-time-step sequencer for the single-clock 64-bit PV result FIFO. Each step it opens a write window of exactly N_PV words from the PV solver, then drains exactly N_PV words to the downstream network solver with a valid strobe aligned to FIFO read data. It replaces the free-running delay-based read/write enables with counted, flag-checked handshakes. It also reports step completion and sticky protocol errors to the system controller.

## Interface
- N_PV, 16: words written and read per simulation step (1..DEPTH)
- DEPTH, 16: FIFO depth in words
- RD_LAT, 1: FIFO read latency, rd_en to q valid, in cycles (1..4)
- CNT_W, 5: counter width, ≥ clog2(N_PV+1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rst_user  in  1  synchronous, active-high user restart; clears everything rst_n clears
- step_start  in  1  one-cycle pulse, begin a step
- src_valid  in  1  solver word present on FIFO data input this cycle
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- wr_en  out  1  FIFO write request
- rd_en  out  1  FIFO read request
- out_valid  out  1  FIFO q holds a valid word this cycle
- busy  out  1  state ≠ IDLE
- step_done  out  1  one-cycle pulse, step complete
- err_ovf  out  1  sticky: src_valid seen with fifo_full during FILL
- err_unf  out  1  sticky: read needed with fifo_empty during DRAIN
- err_overrun  out  1  sticky: step_start while busy

## Operation
- States: IDLE, FILL, DRAIN, FLUSH, DONE.
- IDLE: step_start=1 → FILL; wr_cnt, rd_cnt cleared.
- FILL: wr_en = src_valid & ~fifo_full (combinational). Each wr_en increments wr_cnt. wr_cnt reaching N_PV → DRAIN. src_valid & fifo_full sets err_ovf; that word is dropped and not counted.
- src_valid outside FILL is ignored; no write.
- DRAIN: rd_en = (rd_cnt < N_PV) & ~fifo_empty (combinational). Each rd_en increments rd_cnt. rd_cnt < N_PV & fifo_empty sets err_unf; the sequencer stalls until data arrives. rd_cnt reaching N_PV → FLUSH.
- FLUSH: wait until the out_valid delay line is empty, then → DONE.
- DONE: step_done=1 for this single cycle; → IDLE.
- out_valid = rd_en delayed exactly RD_LAT cycles.
- step_start in any state other than IDLE: ignored, sets err_overrun.
- rst_user=1 in any state: next cycle IDLE, counters 0, delay line cleared, error flags cleared. It overrides step_start in the same cycle.
- The FIFO contents are not cleared by this block.
- Error flags clear only on rst_n or rst_user.

## Timing
- Reset values: wr_en=0, rd_en=0, out_valid=0, busy=0, step_done=0, all err_*=0, state IDLE.
- step_start sampled at edge t → FILL from cycle t+1; first wr_en possible in t+1.
- With src_valid held high and no full: writes in t+1..t+N_PV, DRAIN from t+N_PV+1.
- Reads occur t+N_PV+1..t+2N_PV; out_valid t+N_PV+1+RD_LAT..t+2N_PV+RD_LAT.
- FLUSH occupies cycles until the last out_valid; DONE (step_done) falls in t+2N_PV+RD_LAT+1; IDLE next cycle.
- Minimum step period: 2N_PV+RD_LAT+2 cycles. The next step_start may arrive in the first IDLE cycle.
- The write of word N_PV and the FILL→DRAIN transition happen on the same edge. No read is issued in the cycle that performs the last write.
- Counters saturate at N_PV and never wrap.
- Asynchronous rst_n mid-step takes effect immediately; outputs go to their reset values without waiting for the clock.

## Structure
- Shared package system_fifo_pkg:
  - state enum (IDLE, FILL, DRAIN, FLUSH, DONE)
  - default N_PV, DEPTH, RD_LAT constants
  - clog2-based CNT_W function
- One sub-module: valid_delay_line, an RD_LAT-stage shift register with synchronous clear and a "pipeline empty" output, used for out_valid.
- FSM, counters and error flags stay in the top-level module.

## Test plan
- Nominal, N_PV=16, RD_LAT=1: step_start, src_valid held high → 16 wr_en cycles, then 16 rd_en cycles. out_valid trails rd_en by 1 cycle. step_done exactly 34 cycles after the step_start edge; no errors.
- Bursty source: src_valid toggled 1/0 → 16 writes over 31 cycles, DRAIN entered only after write 16, read count still exactly 16.
- Full FIFO: preload 16 words, then step with src_valid=1 → wr_en stays 0, err_ovf=1 next cycle and remains set through IDLE.
- Empty during drain: N_PV=4 with fifo_empty forced high for 3 DRAIN cycles → rd_en=0 and err_unf=1 in those cycles. Reads resume afterwards; step_done after the 4th out_valid.
- Overrun: step_start again mid-FILL → ignored, err_overrun=1, wr_cnt unaffected, step completes normally.
- Resets: rst_user during DRAIN → IDLE next cycle, out_valid 0, errors cleared. rst_n asserted between edges → all outputs 0 immediately.
